// File: rtl/redma_job_sched.sv
// Round-robin job scheduler that lets NUM_REQ descriptor sources share one DMA datapath.
// Build option: define REDMA_JOB_TIMEOUT_EN to add a WAIT-state watchdog (TIMEOUT_CYCLES) that aborts with done_err.

module redma_job_sched #(
  parameter int NUM_REQ              = 4,
  parameter int INTERNAL_RADDR_WIDTH = 32,
  parameter int INTERNAL_WADDR_WIDTH = 32,
  parameter int BTT_WIDTH            = 32,
  parameter int TIMEOUT_CYCLES       = 65535
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ*INTERNAL_RADDR_WIDTH-1:0] req_raddr,
  input  logic [NUM_REQ*INTERNAL_WADDR_WIDTH-1:0] req_waddr,
  input  logic [NUM_REQ*BTT_WIDTH-1:0]            req_btt,
  input  logic [NUM_REQ-1:0]                      req_write_zero,
  output logic [NUM_REQ-1:0]                      done_valid,
  output logic                                    done_err,
  output logic [INTERNAL_RADDR_WIDTH-1:0]         read_start_addr,
  output logic [INTERNAL_WADDR_WIDTH-1:0]         write_start_addr,
  output logic [BTT_WIDTH-1:0]                    btt,
  output logic                                    write_zero,
  output logic                                    reader_start,
  output logic                                    writer_start,
  input  logic                                    set_reader_intr,
  input  logic                                    set_writer_intr,
  output logic                                    busy,
  output logic [$clog2(NUM_REQ)-1:0]              grant_id
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [IDW-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]                  grant_id_q, grant_id_d;
  logic [INTERNAL_RADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [INTERNAL_WADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [BTT_WIDTH-1:0]            btt_q, btt_d;
  logic                            wzero_q, wzero_d;
  logic                            rdone_q, rdone_d;
  logic                            wdone_q, wdone_d;

  logic                            grant_found;
  logic [IDW-1:0]                  grant_idx;
  logic [INTERNAL_RADDR_WIDTH-1:0] sel_raddr;
  logic [INTERNAL_WADDR_WIDTH-1:0] sel_waddr;
  logic [BTT_WIDTH-1:0]            sel_btt;
  logic                            sel_wzero;

  // Search starts at rr_ptr so the requester served last is considered last.
  always_comb begin
    int slot;
    slot        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = int'(rr_ptr_q) + i;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      if (!grant_found && req_valid[IDW'(slot)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(slot);
      end
    end
  end

  always_comb begin
    sel_raddr = req_raddr[grant_idx*INTERNAL_RADDR_WIDTH +: INTERNAL_RADDR_WIDTH];
    sel_waddr = req_waddr[grant_idx*INTERNAL_WADDR_WIDTH +: INTERNAL_WADDR_WIDTH];
    sel_btt   = req_btt[grant_idx*BTT_WIDTH +: BTT_WIDTH];
    sel_wzero = req_write_zero[grant_idx];
  end

`ifdef REDMA_JOB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // NOTE: every combinational output and next-state value gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    raddr_d      = raddr_q;
    waddr_d      = waddr_q;
    btt_d        = btt_q;
    wzero_d      = wzero_q;
    rdone_d      = rdone_q;
    wdone_d      = wdone_q;
    req_ready    = '0;
    done_valid   = '0;
    reader_start = 1'b0;
    writer_start = 1'b0;
`ifdef REDMA_JOB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          grant_id_d           = grant_idx;
          raddr_d              = sel_raddr;
          waddr_d              = sel_waddr;
          btt_d                = sel_btt;
          wzero_d              = sel_wzero;
          state_d              = (sel_btt == '0) ? DONE : LAUNCH;
        end
      end

      LAUNCH: begin
        writer_start = 1'b1;
        reader_start = !wzero_q;
        // A zero-fill job has no read phase, so its read side counts as already complete.
        rdone_d      = wzero_q;
        wdone_d      = 1'b0;
`ifdef REDMA_JOB_TIMEOUT_EN
        cnt_d        = '0;
`endif
        state_d      = WAIT;
      end

      WAIT: begin
        rdone_d = rdone_q | set_reader_intr;
        wdone_d = wdone_q | set_writer_intr;
`ifdef REDMA_JOB_TIMEOUT_EN
        cnt_d   = cnt_q + 1'b1;
        if (rdone_d && wdone_d) begin
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
`else
        if (rdone_d && wdone_d) state_d = DONE;
`endif
      end

      DONE: begin
        done_valid[grant_id_q] = 1'b1;
        rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        rdone_d  = 1'b0;
        wdone_d  = 1'b0;
`ifdef REDMA_JOB_TIMEOUT_EN
        err_d    = 1'b0;
`endif
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      btt_q      <= '0;
      wzero_q    <= 1'b0;
      rdone_q    <= 1'b0;
      wdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      btt_q      <= btt_d;
      wzero_q    <= wzero_d;
      rdone_q    <= rdone_d;
      wdone_q    <= wdone_d;
    end
  end

`ifdef REDMA_JOB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign done_err = (state_q == DONE) && err_q;
`else
  // Without the watchdog a job can never abort; the limit parameter has no effect.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign done_err           = 1'b0;
`endif

  assign read_start_addr  = raddr_q;
  assign write_start_addr = waddr_q;
  assign btt              = btt_q;
  assign write_zero       = wzero_q;
  assign grant_id         = grant_id_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_redma_job_sched.sv
// Scoreboard bench for redma_job_sched: a queue-based job model predicts grants, launches and done pulses.
// Define REDMA_JOB_TIMEOUT_EN for both files to also exercise the watchdog abort.

module tb_redma_job_sched;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int WW  = 32;
  localparam int BW  = 32;
  localparam int TMO = 100;

  logic          clk             = 1'b0;
  logic          rst             = 1'b1;
  logic [N-1:0]  req_valid       = '0;
  logic [N-1:0]  req_ready;
  logic [N*AW-1:0] req_raddr     = '0;
  logic [N*WW-1:0] req_waddr     = '0;
  logic [N*BW-1:0] req_btt       = '0;
  logic [N-1:0]  req_write_zero  = '0;
  logic [N-1:0]  done_valid;
  logic          done_err;
  logic [AW-1:0] read_start_addr;
  logic [WW-1:0] write_start_addr;
  logic [BW-1:0] btt;
  logic          write_zero;
  logic          reader_start;
  logic          writer_start;
  logic          set_reader_intr = 1'b0;
  logic          set_writer_intr = 1'b0;
  logic          busy;
  logic [1:0]    grant_id;

  redma_job_sched #(
    .NUM_REQ(N), .INTERNAL_RADDR_WIDTH(AW), .INTERNAL_WADDR_WIDTH(WW),
    .BTT_WIDTH(BW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_raddr(req_raddr), .req_waddr(req_waddr), .req_btt(req_btt),
    .req_write_zero(req_write_zero),
    .done_valid(done_valid), .done_err(done_err),
    .read_start_addr(read_start_addr), .write_start_addr(write_start_addr),
    .btt(btt), .write_zero(write_zero),
    .reader_start(reader_start), .writer_start(writer_start),
    .set_reader_intr(set_reader_intr), .set_writer_intr(set_writer_intr),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] btt;
    bit          wz;
    int unsigned cyc;
  } launch_t;

  typedef struct {
    int          id;
    bit          err;
    int unsigned cyc;
  } done_t;

  launch_t launch_q[$];
  done_t   done_q[$];
  launch_t le;
  done_t   de;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: pending descriptors per requester and the round-robin start point.
  logic [31:0] m_raddr [N];
  logic [31:0] m_waddr [N];
  logic [31:0] m_btt   [N];
  bit          m_wz    [N];
  bit          pend    [N];
  int          model_rr = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      if (pend[i]) begin
        req_raddr[i*AW +: AW] = m_raddr[i];
        req_waddr[i*WW +: WW] = m_waddr[i];
        req_btt[i*BW +: BW]   = m_btt[i];
        req_write_zero[i]     = m_wz[i];
      end else begin
        req_raddr[i*AW +: AW] = $urandom;
        req_waddr[i*WW +: WW] = $urandom;
        req_btt[i*BW +: BW]   = $urandom;
        req_write_zero[i]     = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic arm(input int i, input logic [31:0] ra, input logic [31:0] wa,
                     input logic [31:0] b, input bit wz);
    m_raddr[i] = ra;
    m_waddr[i] = wa;
    m_btt[i]   = b;
    m_wz[i]    = wz;
    pend[i]    = 1'b1;
    drive_inputs();
  endtask

  task automatic arm_random(input int i);
    logic [31:0] b;
    b = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
    arm(i, $urandom, $urandom, b, ($urandom_range(0, 3) == 0));
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (pend[(model_rr + k) % N]) return (model_rr + k) % N;
    end
    return -1;
  endfunction

  // Entered and left just after a rising edge. dr/dw are pulse offsets from the first WAIT cycle.
  task automatic do_job(input int dr, input int dw, input bit keep, input bit stray, input bit tmo);
    int          n, g, m;
    int unsigned c;
    bit          zero, wz;
    n = 0;
    #1;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant_seen", longint'(req_ready != '0), 1);
    if (req_ready == '0) return;
    g = pick();
    c = cyc;
    check("req_ready", req_ready, 1 << g);
    zero = (m_btt[g] == 0);
    wz   = m_wz[g];
    m    = tmo ? TMO - 1 : (wz ? dw : ((dr > dw) ? dr : dw));
    if (!zero)
      launch_q.push_back('{id: g, raddr: m_raddr[g], waddr: m_waddr[g], btt: m_btt[g], wz: wz, cyc: c + 1});
    done_q.push_back('{id: g, err: tmo, cyc: zero ? c + 1 : c + 3 + m});
    model_rr = (g + 1) % N;

    @(posedge clk); #1;
    if (keep) arm_random(g);
    else begin
      pend[g] = 1'b0;
      drive_inputs();
    end
    set_reader_intr = stray;
    set_writer_intr = stray;
    @(posedge clk); #1;
    set_reader_intr = 1'b0;
    set_writer_intr = 1'b0;
    if (!zero) begin
      for (int t = 0; t <= m + 1; t++) begin
        set_reader_intr = (!wz && t == dr) || (stray && t == m + 1);
        set_writer_intr = (!tmo && t == dw) || (stray && t == m + 1);
        @(posedge clk); #1;
      end
      set_reader_intr = 1'b0;
      set_writer_intr = 1'b0;
    end
    check("idle_after_job", busy, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_done_valid"}, done_valid, 0);
    check({tag, "_done_err"}, done_err, 0);
    check({tag, "_starts"}, {reader_start, writer_start}, 0);
    check({tag, "_raddr"}, read_start_addr, 0);
    check({tag, "_waddr"}, write_start_addr, 0);
    check({tag, "_btt"}, btt, 0);
    check({tag, "_write_zero"}, write_zero, 0);
    check({tag, "_grant_id"}, grant_id, 0);
  endtask

  task automatic reset_in_wait();
    int          n;
    int unsigned c;
    arm(3, 32'hA000, 32'hB000, 32'd100, 1'b0);
    n = 0;
    #1;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    c = cyc;
    check("rst_job_ready", req_ready, 1 << pick());
    launch_q.push_back('{id: 3, raddr: 32'hA000, waddr: 32'hB000, btt: 32'd100, wz: 1'b0, cyc: c + 1});
    @(posedge clk); #1;
    pend[3] = 1'b0;
    drive_inputs();
    @(posedge clk); #1;
    set_reader_intr = 1'b1;
    @(posedge clk); #1;
    set_reader_intr = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_outputs_zero("rst_in_wait");
    launch_q.delete();
    model_rr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_writer_intr = (i == 1);
      @(posedge clk); #1;
    end
    set_writer_intr = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a launch or a done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) check("ready_while_busy", req_ready, 0);
      if (reader_start || writer_start) begin
        if (launch_q.size() == 0) check("unexpected_start", {reader_start, writer_start}, 0);
        else begin
          le = launch_q.pop_front();
          check("launch_cycle", cyc, le.cyc);
          check("launch_raddr", read_start_addr, le.raddr);
          check("launch_waddr", write_start_addr, le.waddr);
          check("launch_btt", btt, le.btt);
          check("launch_write_zero", write_zero, le.wz);
          check("launch_grant_id", grant_id, le.id);
          check("writer_start", writer_start, 1);
          check("reader_start", reader_start, !le.wz);
        end
      end
      if (done_valid != '0) begin
        if (done_q.size() == 0) check("unexpected_done", done_valid, 0);
        else begin
          de = done_q.pop_front();
          check("done_cycle", cyc, de.cyc);
          check("done_valid", done_valid, 1 << de.id);
          check("done_err", done_err, de.err);
          check("done_grant_id", grant_id, de.id);
        end
      end else begin
        check("done_err_idle", done_err, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single job: reader completes first, writer later.
    arm(0, 32'h1000, 32'h2000, 32'd256, 1'b0);
    do_job(5, 9, 1'b0, 1'b0, 1'b0);

    // Zero-length job goes straight to DONE; rr_ptr then points at requester 2.
    arm(1, 32'h1111, 32'h2222, 32'd0, 1'b0);
    do_job(0, 0, 1'b0, 1'b0, 1'b0);
    arm(0, 32'h3000, 32'h4000, 32'd8, 1'b0);
    arm(2, 32'h5000, 32'h6000, 32'd16, 1'b0);
    do_job(1, 1, 1'b0, 1'b0, 1'b0);
    do_job(2, 0, 1'b0, 1'b0, 1'b0);

    // Zero-fill job: no reader start, writer pulse alone completes it.
    arm(2, 32'h7000, 32'h8000, 32'd64, 1'b1);
    do_job(0, 4, 1'b0, 1'b0, 1'b0);

    // Stray completion pulses in IDLE must not pre-complete the next job.
    set_writer_intr = 1'b1;
    @(posedge clk); #1;
    set_writer_intr = 1'b0;
    set_reader_intr = 1'b1;
    @(posedge clk); #1;
    set_reader_intr = 1'b0;
    arm(3, 32'h9000, 32'h9800, 32'd32, 1'b0);
    do_job(3, 7, 1'b0, 1'b1, 1'b0);

    reset_in_wait();

    // All four requesting continuously: grants rotate 0,1,2,3,0.
    for (int i = 0; i < N; i++) arm(i, 32'h100 * (i + 1), 32'h200 * (i + 1), 32'h10 * (i + 1), 1'b0);
    for (int j = 0; j < 5; j++) do_job(0, 0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    for (int j = 0; j < 40; j++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) arm_random(i);
        any |= pend[i];
      end
      if (!any) arm_random($urandom_range(0, N - 1));
      do_job($urandom_range(0, 6), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), 1'b0);
    end

    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;

`ifdef REDMA_JOB_TIMEOUT_EN
    arm(1, 32'hC000, 32'hD000, 32'd16, 1'b0);
    do_job(5, 0, 1'b0, 1'b0, 1'b1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("launch_q_drained", launch_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/redma_job_sched.md
Name: redma_job_sched

Overview:
- Multi-requester job scheduler in front of one DMA datapath: reader, realigner, writer and write-response engines.
- Arbitrates round-robin between NUM_REQ descriptor sources and drives the DMA start/configuration signals (read/write start address, btt, write_zero, reader/writer start pulses).
- Tracks the reader and writer completion pulses and returns a per-requester done pulse.
- Replaces software-driven sequencing through the AXI-Lite register file when several masters share one DMA.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- INTERNAL_RADDR_WIDTH, 32, read start address width.
- INTERNAL_WADDR_WIDTH, 32, write start address width.
- BTT_WIDTH, 32, bytes-to-transfer width.
- TIMEOUT_CYCLES, 65535, watchdog limit; used only with REDMA_JOB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  descriptor valid per requester
- req_ready  out  NUM_REQ  descriptor accepted (one-hot or zero)
- req_raddr  in  NUM_REQ*INTERNAL_RADDR_WIDTH  packed read addresses; requester i at slice i
- req_waddr  in  NUM_REQ*INTERNAL_WADDR_WIDTH  packed write addresses
- req_btt  in  NUM_REQ*BTT_WIDTH  packed byte counts
- req_write_zero  in  NUM_REQ  zero-fill job (no read)
- done_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
- done_err  out  1  qualifies done_valid; timeout abort
- read_start_addr  out  INTERNAL_RADDR_WIDTH  to DMA
- write_start_addr  out  INTERNAL_WADDR_WIDTH  to DMA
- btt  out  BTT_WIDTH  to DMA
- write_zero  out  1  to DMA
- reader_start  out  1  one-cycle start pulse
- writer_start  out  1  one-cycle start pulse
- set_reader_intr  in  1  reader-side completion pulse
- set_writer_intr  in  1  write-response completion pulse
- busy  out  1  state != IDLE
- grant_id  out  $clog2(NUM_REQ)  owner of the current job

Behaviour:
- States: IDLE, LAUNCH, WAIT, DONE.
- Reset (async, rst=1): state=IDLE, rr_ptr=0, all outputs 0, rdone/wdone flags=0. Reset in any state abandons the job; no done pulse is issued.
- IDLE, arbitration:
  - The grant is the first requester with req_valid set, searching from rr_ptr upward and wrapping mod NUM_REQ.
  - req_ready[g] = 1 combinationally in the same cycle (valid&ready handshake).
  - On the handshake, register read_start_addr, write_start_addr, btt, write_zero and grant_id from slice g.
  - Next state is LAUNCH, or DONE if req_btt[g]==0.
  - req_ready is 0 in every other state.
- Config outputs hold their values until the next accepted handshake, including through DONE and IDLE.
- LAUNCH:
  - Exactly 1 cycle.
  - writer_start=1.
  - reader_start = !write_zero.
  - rdone is preset to write_zero; wdone=0.
  - Next state: WAIT.
- WAIT:
  - set_reader_intr sets rdone; set_writer_intr sets wdone. Both flags are sticky, and simultaneous pulses set both.
  - When rdone&wdone are both set (including flags set this cycle), go to DONE.
  - Completion pulses arriving in IDLE, LAUNCH or DONE are ignored.
- DONE:
  - 1 cycle: done_valid[grant_id]=1, done_err as defined below.
  - rr_ptr = (grant_id+1) mod NUM_REQ.
  - Clear both flags; next state: IDLE.
- Minimum latency, handshake to done_valid: 3 cycles (LAUNCH, WAIT with both pulses, DONE). A btt=0 job takes 1 cycle (DONE directly) and issues no start pulses.
- Fairness: the requester just served has the lowest priority in the next arbitration. No starvation.
- The descriptor must be stable only in the handshake cycle.

Optional Feature:
- REDMA_JOB_TIMEOUT_EN defined:
  - A cycle counter of width $clog2(TIMEOUT_CYCLES+1) clears in LAUNCH and increments in WAIT.
  - When it reaches TIMEOUT_CYCLES with the flags incomplete, go to DONE with done_err=1.
  - The DMA is not otherwise touched; software resets the DMA.
- Undefined: no counter, WAIT can last indefinitely, done_err is constant 0.

Test Plan:
- Single job:
  - Stimulus: req0 raddr=0x1000, waddr=0x2000, btt=256.
  - Response: req_ready[0] in cycle 0; LAUNCH in cycle 1 with both starts and outputs 0x1000/0x2000/256.
  - Reader pulse at +5, writer pulse at +9 → done_valid[0] exactly 1 cycle after the writer pulse.
- Round-robin:
  - Stimulus: req_valid=4'b1111 held, each job completed with immediate simultaneous intr pulses.
  - Response: grant order 0,1,2,3,0; each done_valid goes to the matching bit.
- write_zero job:
  - Stimulus: req2 write_zero=1, btt=64.
  - Response: reader_start stays 0, writer_start=1; done follows set_writer_intr alone.
- btt=0:
  - Stimulus: req1 btt=0.
  - Response: no start pulses; done_valid[1] 1 cycle after the handshake; rr_ptr=2.
- Stray pulses:
  - Stimulus: set_writer_intr in IDLE, and an async rst in WAIT.
  - Response: the stray pulse is ignored. After reset all outputs are 0, busy=0, and no done pulse is issued.
- Timeout (with REDMA_JOB_TIMEOUT_EN, TIMEOUT_CYCLES=100):
  - Stimulus: no writer intr.
  - Response: done_valid with done_err=1 after 100 WAIT cycles.
